// File: rtl/counter_seq_ctrl_pkg.sv
// Shared constants for the counter sequencer: opcodes, state encodings,
// io_in/io_out field positions and the status packing helper.
package counter_seq_ctrl_pkg;

  localparam int IO_W = 28;

  // io_in fields
  localparam int IO_STB_BIT  = 0;
  localparam int IO_OP_LSB   = 1;
  localparam int IO_OP_W     = 3;
  localparam int IO_DATA_LSB = 4;
  localparam int IO_DATA_W   = 16;
  localparam int IO_IN_USED  = IO_DATA_LSB + IO_DATA_W;

  // io_out fields
  localparam int OUT_COUNT_LSB  = 0;
  localparam int OUT_COUNT_W    = 16;
  localparam int OUT_STATE_LSB  = 16;
  localparam int OUT_PULSE_BIT  = 18;
  localparam int OUT_STICKY_BIT = 19;
  localparam int OUT_USED       = 20;

  typedef enum logic [IO_OP_W-1:0] {
    OP_NOP            = 3'd0,
    OP_LOAD_LIMIT     = 3'd1,
    OP_START_ONESHOT  = 3'd2,
    OP_START_PERIODIC = 3'd3,
    OP_PAUSE          = 3'd4,
    OP_RESUME         = 3'd5,
    OP_STOP           = 3'd6,
    OP_LOAD_PRESCALE  = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

  function automatic logic [IO_W-1:0] pack_status(
    input logic [OUT_COUNT_W-1:0] count,
    input state_e                 state,
    input logic                   done_pulse,
    input logic                   done_sticky
  );
    logic [IO_W-1:0] word;
    word = '0;
    word[OUT_COUNT_LSB +: OUT_COUNT_W] = count;
    word[OUT_STATE_LSB +: 2]           = state;
    word[OUT_PULSE_BIT]                = done_pulse;
    word[OUT_STICKY_BIT]               = done_sticky;
    return word;
  endfunction

endpackage

// File: rtl/seq_counter_core.sv
// WIDTH-bit event counter register: clear wins over enable, count wraps naturally.
module seq_counter_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Command-driven sequencer for a 16-bit event counter: decodes strobed
// opcodes, owns limit/prescale configuration, prescaler and run FSM.
module counter_seq_ctrl
  import counter_seq_ctrl_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               PRE_W     = 8,
  parameter logic [WIDTH-1:0] LIMIT_RST = 16'hFFFF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IO_W-1:0] io_in,
  output logic [IO_W-1:0] io_out,
  output logic [IO_W-1:0] io_oeb
);

  // Command decode
  logic                 cmd_stb;
  opcode_e              cmd_op;
  logic [IO_DATA_W-1:0] cmd_data;
  logic                 unused_io_hi;

  assign cmd_stb      = io_in[IO_STB_BIT];
  assign cmd_op       = opcode_e'(io_in[IO_OP_LSB +: IO_OP_W]);
  assign cmd_data     = io_in[IO_DATA_LSB +: IO_DATA_W];
  assign unused_io_hi = ^io_in[IO_W-1:IO_IN_USED];

  // Registered state
  logic             strobe_q;
  state_e           state_q,      state_d;
  mode_e            mode_q,       mode_d;
  logic [WIDTH-1:0] limit_q,      limit_d;
  logic [PRE_W-1:0] prescale_q,   prescale_d;
  logic [PRE_W-1:0] pre_cnt_q,    pre_cnt_d;
  logic             done_pulse_q, done_pulse_d;
  logic             sticky_q,     sticky_d;

  logic             accept;
  logic             cmd_active;
  logic             tick;
  logic             terminal;
  logic             cnt_en;
  logic             cnt_clr;
  logic [WIDTH-1:0] count;

  assign accept     = cmd_stb & ~strobe_q;
  assign cmd_active = accept && (cmd_op != OP_NOP);
  // >= keeps the prescaler from running away if prescale is lowered mid-period
  assign tick       = (state_q == ST_RUN) && (pre_cnt_q >= prescale_q);
  assign terminal   = tick && (count >= limit_q);

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    limit_d      = limit_q;
    prescale_d   = prescale_q;
    pre_cnt_d    = pre_cnt_q;
    sticky_d     = sticky_q;
    done_pulse_d = 1'b0;
    cnt_en       = 1'b0;
    cnt_clr      = 1'b0;

    // An accepted command owns its cycle: prescaler, counter and done
    // reporting stand still while it takes effect.
    if (cmd_active) begin
      case (cmd_op)
        OP_LOAD_LIMIT: begin
          limit_d = cmd_data[WIDTH-1:0];
        end
        OP_START_ONESHOT, OP_START_PERIODIC: begin
          state_d   = ST_RUN;
          mode_d    = (cmd_op == OP_START_PERIODIC) ? MODE_PERIODIC : MODE_ONESHOT;
          pre_cnt_d = '0;
          sticky_d  = 1'b0;
          cnt_clr   = 1'b1;
        end
        OP_PAUSE: begin
          if (state_q == ST_RUN) begin
            state_d = ST_PAUSED;
          end
        end
        OP_RESUME: begin
          if (state_q == ST_PAUSED) begin
            state_d = ST_RUN;
          end
        end
        OP_STOP: begin
          state_d   = ST_IDLE;
          pre_cnt_d = '0;
          sticky_d  = 1'b0;
          cnt_clr   = 1'b1;
        end
        OP_LOAD_PRESCALE: begin
          prescale_d = cmd_data[PRE_W-1:0];
        end
        default: begin
        end
      endcase
    end else if (state_q == ST_RUN) begin
      if (tick) begin
        pre_cnt_d = '0;
        if (terminal) begin
          done_pulse_d = 1'b1;
          sticky_d     = 1'b1;
          if (mode_q == MODE_PERIODIC) begin
            cnt_clr = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end else begin
        pre_cnt_d = pre_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q     <= 1'b0;
      state_q      <= ST_IDLE;
      mode_q       <= MODE_ONESHOT;
      limit_q      <= LIMIT_RST;
      prescale_q   <= '0;
      pre_cnt_q    <= '0;
      done_pulse_q <= 1'b0;
      sticky_q     <= 1'b0;
    end else begin
      strobe_q     <= cmd_stb;
      state_q      <= state_d;
      mode_q       <= mode_d;
      limit_q      <= limit_d;
      prescale_q   <= prescale_d;
      pre_cnt_q    <= pre_cnt_d;
      done_pulse_q <= done_pulse_d;
      sticky_q     <= sticky_d;
    end
  end

  seq_counter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .count (count)
  );

  assign io_out = pack_status(count, state_q, done_pulse_q, sticky_q);
  assign io_oeb = '1;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl: randomized limit/prescale runs
// compared against closed-form expectations of count, state and done flags.
module tb_counter_seq_ctrl;

  localparam logic [2:0] C_LOAD_LIMIT     = 3'd1;
  localparam logic [2:0] C_START_ONESHOT  = 3'd2;
  localparam logic [2:0] C_START_PERIODIC = 3'd3;
  localparam logic [2:0] C_PAUSE          = 3'd4;
  localparam logic [2:0] C_RESUME         = 3'd5;
  localparam logic [2:0] C_STOP           = 3'd6;
  localparam logic [2:0] C_LOAD_PRESCALE  = 3'd7;

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_RUN    = 2'b01;
  localparam logic [1:0] S_PAUSED = 2'b10;
  localparam logic [1:0] S_DONE   = 2'b11;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [27:0] io_in = '0;
  logic [27:0] io_out;
  logic [27:0] io_oeb;

  int n_checks = 0;
  int n_fail   = 0;

  counter_seq_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_in  (io_in),
    .io_out (io_out),
    .io_oeb (io_oeb)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] pack(input int cnt, input logic [1:0] st,
                                       input bit pulse, input bit sticky);
    logic [15:0] c;
    c = cnt[15:0];
    return {8'h00, sticky, pulse, st, c};
  endfunction

  // k = clock edges since the accepting edge of START; a tick lands on every
  // edge that is a multiple of prescale+1.
  function automatic logic [27:0] model_oneshot(input int k, input int lim, input int pre);
    int n;
    bit on_tick;
    n       = k / (pre + 1);
    on_tick = (k % (pre + 1)) == 0;
    if (n > lim) return pack(lim, S_DONE, on_tick && (n == lim + 1), 1'b1);
    return pack(n, S_RUN, 1'b0, 1'b0);
  endfunction

  function automatic logic [27:0] model_periodic(input int k, input int lim, input int pre);
    int n;
    bit on_tick;
    n       = k / (pre + 1);
    on_tick = (k % (pre + 1)) == 0;
    return pack(n % (lim + 1), S_RUN, on_tick && (n > 0) && (n % (lim + 1) == 0),
                n >= lim + 1);
  endfunction

  // Called at a negedge; returns at the negedge after the edge following acceptance.
  task automatic send_cmd(input logic [2:0] op, input logic [15:0] data);
    io_in = {8'h00, data, op, 1'b1};
    @(negedge clk);
    io_in[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    io_in = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (io_out !== 28'h0) begin
        n_fail++;
        $display("FAIL reset_hold: io_out=%h expected %h", io_out, 28'h0);
      end
    end
    n_checks++;
    if (io_oeb !== 28'hFFFFFFF) begin
      n_fail++;
      $display("FAIL io_oeb: got %h expected %h", io_oeb, 28'hFFFFFFF);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (io_out !== 28'h0) begin
        n_fail++;
        $display("FAIL reset_idle: cycle %0d io_out=%h expected %h", i, io_out, 28'h0);
      end
    end
    $display("test_reset: done");
  endtask

  task automatic test_oneshot();
    for (int r = 0; r < 4; r++) begin
      int lim, pre, pulses;
      lim = (r == 0) ? 5 : (r == 1) ? 0 : int'($urandom_range(1, 12));
      pre = (r == 0) ? 0 : int'($urandom_range(0, 3));
      pulses = 0;
      send_cmd(C_LOAD_PRESCALE, 16'(pre));
      send_cmd(C_LOAD_LIMIT, 16'(lim));
      send_cmd(C_START_ONESHOT, 16'h0);
      for (int k = 1; k <= (lim + 3) * (pre + 1); k++) begin
        logic [27:0] exp_w;
        exp_w = model_oneshot(k, lim, pre);
        pulses += int'(io_out[18]);
        n_checks++;
        if (io_out !== exp_w) begin
          n_fail++;
          $display("FAIL oneshot: lim=%0d pre=%0d k=%0d io_out=%h expected %h",
                   lim, pre, k, io_out, exp_w);
        end
        @(negedge clk);
      end
      n_checks++;
      if (pulses != 1) begin
        n_fail++;
        $display("FAIL oneshot_pulses: lim=%0d pre=%0d got %0d expected 1", lim, pre, pulses);
      end
      $display("test_oneshot: lim=%0d pre=%0d pulses=%0d", lim, pre, pulses);
    end
  endtask

  task automatic test_periodic();
    for (int r = 0; r < 3; r++) begin
      int lim, pre, pulses;
      lim = (r == 0) ? 3 : (r == 1) ? 0 : int'($urandom_range(1, 8));
      pre = (r == 0) ? 2 : int'($urandom_range(0, 2));
      pulses = 0;
      send_cmd(C_LOAD_PRESCALE, 16'(pre));
      send_cmd(C_LOAD_LIMIT, 16'(lim));
      send_cmd(C_START_PERIODIC, 16'h0);
      for (int k = 1; k <= 3 * (lim + 1) * (pre + 1); k++) begin
        logic [27:0] exp_w;
        exp_w = model_periodic(k, lim, pre);
        pulses += int'(io_out[18]);
        n_checks++;
        if (io_out !== exp_w) begin
          n_fail++;
          $display("FAIL periodic: lim=%0d pre=%0d k=%0d io_out=%h expected %h",
                   lim, pre, k, io_out, exp_w);
        end
        if (k != 3 * (lim + 1) * (pre + 1)) @(negedge clk);
      end
      n_checks++;
      if (pulses != 3) begin
        n_fail++;
        $display("FAIL periodic_pulses: lim=%0d pre=%0d got %0d expected 3", lim, pre, pulses);
      end
      $display("test_periodic: lim=%0d pre=%0d pulses=%0d", lim, pre, pulses);
      @(negedge clk);
    end
  endtask

  task automatic test_pause_resume();
    int pre;
    pre = int'($urandom_range(0, 3));
    send_cmd(C_LOAD_PRESCALE, 16'(pre));
    send_cmd(C_LOAD_LIMIT, 16'd100);
    send_cmd(C_START_PERIODIC, 16'h0);
    for (int k = 1; k < 4 * (pre + 1); k++) @(negedge clk);
    n_checks++;
    if (io_out !== pack(4, S_RUN, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL pause_entry: io_out=%h expected %h", io_out, pack(4, S_RUN, 1'b0, 1'b0));
    end
    send_cmd(C_PAUSE, 16'h0);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (io_out !== pack(4, S_PAUSED, 1'b0, 1'b0)) begin
        n_fail++;
        $display("FAIL paused: cycle %0d io_out=%h expected %h", i, io_out,
                 pack(4, S_PAUSED, 1'b0, 1'b0));
      end
      @(negedge clk);
    end
    send_cmd(C_RESUME, 16'h0);
    for (int j = 1; j <= 3 * (pre + 1); j++) begin
      logic [27:0] exp_w;
      exp_w = pack(4 + j / (pre + 1), S_RUN, 1'b0, 1'b0);
      n_checks++;
      if (io_out !== exp_w) begin
        n_fail++;
        $display("FAIL resumed: pre=%0d j=%0d io_out=%h expected %h", pre, j, io_out, exp_w);
      end
      @(negedge clk);
    end
    send_cmd(C_STOP, 16'h0);
    n_checks++;
    if (io_out !== 28'h0) begin
      n_fail++;
      $display("FAIL stop: io_out=%h expected %h", io_out, 28'h0);
    end
    send_cmd(C_RESUME, 16'h0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (io_out !== 28'h0) begin
        n_fail++;
        $display("FAIL resume_in_idle: cycle %0d io_out=%h expected %h", i, io_out, 28'h0);
      end
      @(negedge clk);
    end
    send_cmd(C_PAUSE, 16'h0);
    n_checks++;
    if (io_out !== 28'h0) begin
      n_fail++;
      $display("FAIL pause_in_idle: io_out=%h expected %h", io_out, 28'h0);
    end
    $display("test_pause_resume: pre=%0d done", pre);
  endtask

  task automatic test_strobe_held_and_limit_lowered();
    send_cmd(C_LOAD_PRESCALE, 16'h0);
    send_cmd(C_LOAD_LIMIT, 16'd1000);
    io_in = {8'h00, 16'h0, C_START_ONESHOT, 1'b1};
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      if (j == 8) io_in[0] = 1'b0;
      n_checks++;
      if (io_out !== pack(j - 1, S_RUN, 1'b0, 1'b0)) begin
        n_fail++;
        $display("FAIL strobe_held: j=%0d io_out=%h expected %h", j, io_out,
                 pack(j - 1, S_RUN, 1'b0, 1'b0));
      end
    end
    send_cmd(C_LOAD_LIMIT, 16'd4);
    n_checks++;
    if (io_out !== pack(10, S_DONE, 1'b1, 1'b1)) begin
      n_fail++;
      $display("FAIL limit_lowered: io_out=%h expected %h", io_out, pack(10, S_DONE, 1'b1, 1'b1));
    end
    @(negedge clk);
    n_checks++;
    if (io_out !== pack(10, S_DONE, 1'b0, 1'b1)) begin
      n_fail++;
      $display("FAIL done_hold: io_out=%h expected %h", io_out, pack(10, S_DONE, 1'b0, 1'b1));
    end
    $display("test_strobe_held_and_limit_lowered: done");
  endtask

  task automatic test_async_reset();
    int pre;
    pre = int'($urandom_range(0, 3));
    send_cmd(C_LOAD_PRESCALE, 16'(pre));
    send_cmd(C_LOAD_LIMIT, 16'd50);
    send_cmd(C_START_ONESHOT, 16'h0);
    for (int k = 1; k < 7 * (pre + 1); k++) @(negedge clk);
    n_checks++;
    if (io_out !== pack(7, S_RUN, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL pre_reset: io_out=%h expected %h", io_out, pack(7, S_RUN, 1'b0, 1'b0));
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (io_out !== 28'h0) begin
      n_fail++;
      $display("FAIL async_reset: io_out=%h expected %h", io_out, 28'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (io_out !== 28'h0) begin
        n_fail++;
        $display("FAIL post_reset: cycle %0d io_out=%h expected %h", i, io_out, 28'h0);
      end
    end
    // Reset limit must be far above 300 and prescale back at 0
    send_cmd(C_START_ONESHOT, 16'h0);
    for (int k = 1; k <= 300; k++) begin
      n_checks++;
      if (io_out !== pack(k, S_RUN, 1'b0, 1'b0)) begin
        n_fail++;
        $display("FAIL reset_limit: k=%0d io_out=%h expected %h", k, io_out,
                 pack(k, S_RUN, 1'b0, 1'b0));
      end
      @(negedge clk);
    end
    $display("test_async_reset: pre=%0d done", pre);
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause_resume();
    test_strobe_held_and_limit_lowered();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
